// File: rtl/conv2_window_buf.sv
// 3x3xNUM_CH sliding window generator for binary conv2 feature maps.
// Two row buffers plus a 3x3 shift register; one registered window per completing pixel.
module conv2_window_buf #(
  parameter int IMG_WIDTH  = 13,
  parameter int IMG_HEIGHT = 13,
  parameter int NUM_CH     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [NUM_CH-1:0]     pixel_in,
  output logic [9*NUM_CH-1:0]   pixel_windows,
  output logic                  valid_in_buf,
  output logic                  frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]     col_reg;
  logic [RW-1:0]     row_reg;
  logic [NUM_CH-1:0] line0_mem [IMG_WIDTH];
  logic [NUM_CH-1:0] line1_mem [IMG_WIDTH];
  logic [NUM_CH-1:0] win_reg   [3][3];
  logic [NUM_CH-1:0] tap       [3];
  logic [9*NUM_CH-1:0] win_next;

  logic col_last;
  logic row_last;
  logic complete;

  assign col_last = (col_reg == COL_LAST);
  assign row_last = (row_reg == ROW_LAST);
  assign complete = valid_in && (row_reg >= ROW_TWO) && (col_reg >= COL_TWO);

  // Incoming column, oldest row on top: two rows back, one row back, current pixel.
  assign tap[0] = line0_mem[col_reg];
  assign tap[1] = line1_mem[col_reg];
  assign tap[2] = pixel_in;

  // Window as it will look once the current pixel has been shifted in.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      for (gj = 0; gj < 3; gj++) begin : g_col
        if (gj < 2) begin : g_shift
          assign win_next[(gi*3+gj)*NUM_CH +: NUM_CH] = win_reg[gi][gj+1];
        end else begin : g_new
          assign win_next[(gi*3+gj)*NUM_CH +: NUM_CH] = tap[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (valid_in) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_last ? '0 : row_reg + RW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_WIDTH; i++) begin
        line0_mem[i] <= '0;
        line1_mem[i] <= '0;
      end
    end else if (valid_in) begin
      line0_mem[col_reg] <= line1_mem[col_reg];
      line1_mem[col_reg] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_reg[r][c] <= '0;
        end
      end
    end else if (valid_in) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_reg[r][c] <= win_next[(r*3+c)*NUM_CH +: NUM_CH];
        end
      end
    end
  end

  // Output register only loads on a completing pixel, so it holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_windows <= '0;
      valid_in_buf  <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      valid_in_buf <= complete;
      frame_done   <= complete && col_last && row_last;
      if (complete) begin
        pixel_windows <= win_next;
      end
    end
  end

endmodule

// File: tb/tb_conv2_window_buf.sv
// Directed bench for conv2_window_buf: all-ones, index, gapped, back-to-back and reset frames.
// Reference windows come from a full image array captured by the bench.
module tb_conv2_window_buf;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [7:0]  pixel_in;
  logic [71:0] pixel_windows;
  logic        valid_in_buf;
  logic        frame_done;

  conv2_window_buf #(.IMG_WIDTH(13), .IMG_HEIGHT(13), .NUM_CH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .pixel_in      (pixel_in),
    .pixel_windows (pixel_windows),
    .valid_in_buf  (valid_in_buf),
    .frame_done    (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [71:0] ONES_WIN  = 72'hFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [71:0] FIRST_WIN = 72'h1C1B1A0F0E0D020100;
  localparam logic [71:0] LAST_WIN  = 72'hA8A7A69B9A998E8D8C;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  img [13][13];
  int          m_row = 0;
  int          m_col = 0;
  logic [71:0] last_win = '0;

  int          obs_strobes;
  int          obs_fd;
  int          first_idx;
  int          pix_idx;
  logic [71:0] first_win_obs;
  logic [71:0] last_win_obs;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns after the rising edge.
  task automatic step(input logic v, input logic [7:0] p);
    logic        exp_s;
    logic        exp_f;
    logic [71:0] exp_w;
    @(negedge clk);
    valid_in = v;
    pixel_in = p;
    @(posedge clk);
    #1;
    exp_s = 1'b0;
    exp_f = 1'b0;
    exp_w = last_win;
    if (v) begin
      img[m_row][m_col] = p;
      if (m_row >= 2 && m_col >= 2) begin
        exp_s = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_w[(r*3+c)*8 +: 8] = img[m_row-2+r][m_col-2+c];
      end
      exp_f = (m_row == 12 && m_col == 12);
      if (valid_in_buf && first_idx < 0) first_idx = pix_idx;
      if (exp_s && m_row == 2 && m_col == 2) first_win_obs = pixel_windows;
      if (exp_s && m_row == 12 && m_col == 12) last_win_obs = pixel_windows;
      pix_idx++;
      if (m_col == 12) begin
        m_col = 0;
        m_row = (m_row == 12) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    if (valid_in_buf) obs_strobes++;
    if (frame_done) obs_fd++;
    check("strobe", 72'(valid_in_buf), 72'(exp_s));
    check(exp_s ? "window" : "hold", pixel_windows, exp_w);
    check("frame_done", 72'(frame_done), 72'(exp_f));
    last_win = exp_w;
  endtask

  // mode 0: all ones, 1: index frame, 2: index frame with an idle cycle after each pixel
  task automatic run_frame(input int mode, input string name);
    logic [7:0] p;
    obs_strobes   = 0;
    obs_fd        = 0;
    first_idx     = -1;
    pix_idx       = 0;
    first_win_obs = '0;
    last_win_obs  = '0;
    for (int i = 0; i < 169; i++) begin
      p = (mode == 0) ? 8'hFF : 8'(i);
      step(1'b1, p);
      if (mode == 2) step(1'b0, 8'($urandom));
    end
    check({name, "_strobes"}, 72'(obs_strobes), 72'd121);
    check({name, "_frame_done"}, 72'(obs_fd), 72'd1);
    check({name, "_first_idx"}, 72'(first_idx), 72'd28);
    check({name, "_first_win"}, first_win_obs, (mode == 0) ? ONES_WIN : FIRST_WIN);
    check({name, "_last_win"}, last_win_obs, (mode == 0) ? ONES_WIN : LAST_WIN);
    $display("frame %s: strobes=%0d frame_done=%0d first_idx=%0d first=%h last=%h",
             name, obs_strobes, obs_fd, first_idx, first_win_obs, last_win_obs);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_win"}, pixel_windows, 72'd0);
    check({tag, "_vld"}, 72'(valid_in_buf), 72'd0);
    check({tag, "_fd"}, 72'(frame_done), 72'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    pixel_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(0, "ones");
    run_frame(1, "index");
    run_frame(2, "gapped");
    run_frame(1, "b2b_1");
    run_frame(1, "b2b_2");

    // Partial frame through pixel 50, then asynchronous reset with valid_in held high.
    for (int i = 0; i <= 50; i++) step(1'b1, 8'(i));
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b1;
    pixel_in = 8'h55;
    #1;
    check_reset_outputs("midreset_async");
    @(posedge clk);
    #1;
    check_reset_outputs("midreset_held");
    @(negedge clk);
    rst_n    = 1'b1;
    valid_in = 1'b0;
    m_row    = 0;
    m_col    = 0;
    last_win = '0;
    $display("reset pulsed after pixel 50");
    run_frame(1, "after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
